// File: rtl/stream_pool_layer.sv
// ============================================================================
// Module   : stream_pool_layer
// Brief    : Streaming FxF max/average pooling over a raster pixel stream,
//            with line buffers, stride, fused ReLU and sof resync.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_pool_layer #(
   parameter int I_WIDTH     = 16,
   parameter int CHANNELS    = 5,
   parameter int IMAGE_SIZE  = 15,
   parameter int FILTER_SIZE = 2,
   parameter int STRIDE      = 2,
   parameter int MODE        = 0,
   parameter int RELU        = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clk_en,
   input  logic                          sof,
   input  logic [CHANNELS*I_WIDTH-1:0]   input_data,
   output logic [CHANNELS*I_WIDTH-1:0]   output_data,
   output logic                          valid,
   output logic                          frame_done
);

   localparam int c_DW       = CHANNELS * I_WIDTH;
   localparam int c_CW       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
   localparam int c_LOG2F    = $clog2(FILTER_SIZE);
   localparam int c_SW       = I_WIDTH + 2 * c_LOG2F;
   localparam int c_OUT_SIZE = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
   localparam int c_LAST     = (c_OUT_SIZE - 1) * STRIDE + FILTER_SIZE - 1;

   if (FILTER_SIZE < 1 || FILTER_SIZE > IMAGE_SIZE) begin : g_bad_filter
      $error("stream_pool_layer: FILTER_SIZE must be in 1..IMAGE_SIZE");
   end
   if (STRIDE < 1 || STRIDE > FILTER_SIZE) begin : g_bad_stride
      $error("stream_pool_layer: STRIDE must be in 1..FILTER_SIZE");
   end
   if (MODE == 1 && !(FILTER_SIZE == 1 || FILTER_SIZE == 2 ||
                      FILTER_SIZE == 4 || FILTER_SIZE == 8)) begin : g_bad_avg
      $error("stream_pool_layer: average mode needs FILTER_SIZE in {1,2,4,8}");
   end

   logic [c_CW-1:0] r_row, r_col;
   logic [c_CW-1:0] w_row, w_col, w_row_nxt, w_col_nxt;
   logic            w_fire, w_last;
   logic            r_fire, r_last;

   logic [FILTER_SIZE-1:0][c_DW-1:0] w_new_col;
   logic [c_DW-1:0]                  r_win [FILTER_SIZE][FILTER_SIZE];
   logic [c_DW-1:0]                  w_result;

   logic signed [I_WIDTH-1:0] w_px, w_max, w_res;
   logic signed [c_SW-1:0]    w_sum;

   // sof forces the current pixel to (0,0); the counters hold the next position
   always_comb begin
      w_row     = sof ? '0 : r_row;
      w_col     = sof ? '0 : r_col;
      w_row_nxt = w_row;
      w_col_nxt = w_col + c_CW'(1);
      if (w_col == c_CW'(IMAGE_SIZE - 1)) begin
         w_col_nxt = '0;
         w_row_nxt = (w_row == c_CW'(IMAGE_SIZE - 1)) ? '0 : w_row + c_CW'(1);
      end
   end

   always_comb begin
      w_fire = (int'(w_row) >= FILTER_SIZE - 1) &&
               (int'(w_col) >= FILTER_SIZE - 1) &&
               (((int'(w_row) - (FILTER_SIZE - 1)) % STRIDE) == 0) &&
               (((int'(w_col) - (FILTER_SIZE - 1)) % STRIDE) == 0);
      w_last = (int'(w_row) == c_LAST) && (int'(w_col) == c_LAST);
   end

   assign w_new_col[FILTER_SIZE-1] = input_data;

   // r_lb[k] holds row (r-1-k) at each column
   if (FILTER_SIZE > 1) begin : g_lb
      logic [c_DW-1:0] r_lb [FILTER_SIZE-1][IMAGE_SIZE];

      always_ff @(posedge clk) begin
         if (clk_en) begin
            r_lb[0][w_col] <= input_data;
            for (int k = 1; k < FILTER_SIZE - 1; k++) begin
               r_lb[k][w_col] <= r_lb[k-1][w_col];
            end
         end
      end

      for (genvar i = 0; i < FILTER_SIZE - 1; i++) begin : g_rd
         assign w_new_col[i] = r_lb[FILTER_SIZE-2-i][w_col];
      end
   end

   // window row 0 is the oldest row, column FILTER_SIZE-1 the newest column
   always_ff @(posedge clk) begin
      if (clk_en) begin
         for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < FILTER_SIZE - 1; j++) begin
               r_win[i][j] <= r_win[i][j+1];
            end
            r_win[i][FILTER_SIZE-1] <= w_new_col[i];
         end
      end
   end

   always_comb begin
      w_result = '0;
      w_px     = '0;
      w_max    = '0;
      w_sum    = '0;
      w_res    = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         w_max = r_win[0][0][ch*I_WIDTH +: I_WIDTH];
         w_sum = '0;
         for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < FILTER_SIZE; j++) begin
               w_px = r_win[i][j][ch*I_WIDTH +: I_WIDTH];
               if (w_px > w_max) w_max = w_px;
               w_sum = w_sum + c_SW'(w_px);
            end
         end
         w_res = (MODE == 1) ? I_WIDTH'(w_sum >>> (2 * c_LOG2F)) : w_max;
         if (RELU == 1 && w_res[I_WIDTH-1]) w_res = '0;
         w_result[ch*I_WIDTH +: I_WIDTH] = w_res;
      end
   end

   // fire is captured with the window; the result leaves one edge later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row       <= '0;
         r_col       <= '0;
         r_fire      <= 1'b0;
         r_last      <= 1'b0;
         output_data <= '0;
         valid       <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         r_fire     <= clk_en & w_fire;
         r_last     <= clk_en & w_fire & w_last;
         valid      <= r_fire;
         frame_done <= r_last;
         if (r_fire) output_data <= w_result;
         if (clk_en) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stream_pool_layer.sv
// ============================================================================
// Module   : tb_stream_pool_layer
// Brief    : Randomized self-checking bench for stream_pool_layer (three
//            geometries sharing one pixel stream, each with its own model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_pool_layer;

   localparam int IW = 16;
   localparam int CH = 5;
   localparam int DW = IW * CH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_en = 1'b0;
   logic          sof = 1'b0;
   logic [DW-1:0] input_data = '0;

   logic [DW-1:0] od [3];
   logic          vd [3];
   logic          fd [3];

   always #5 clk = ~clk;

   stream_pool_layer #(.I_WIDTH(IW), .CHANNELS(CH), .IMAGE_SIZE(15), .FILTER_SIZE(2),
                       .STRIDE(2), .MODE(0), .RELU(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sof(sof), .input_data(input_data),
      .output_data(od[0]), .valid(vd[0]), .frame_done(fd[0]));

   stream_pool_layer #(.I_WIDTH(IW), .CHANNELS(CH), .IMAGE_SIZE(10), .FILTER_SIZE(4),
                       .STRIDE(2), .MODE(1), .RELU(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sof(sof), .input_data(input_data),
      .output_data(od[1]), .valid(vd[1]), .frame_done(fd[1]));

   stream_pool_layer #(.I_WIDTH(IW), .CHANNELS(CH), .IMAGE_SIZE(5), .FILTER_SIZE(3),
                       .STRIDE(1), .MODE(0), .RELU(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sof(sof), .input_data(input_data),
      .output_data(od[2]), .valid(vd[2]), .frame_done(fd[2]));

   int p_n  [3] = '{15, 10, 5};
   int p_f  [3] = '{2, 4, 3};
   int p_s  [3] = '{2, 2, 1};
   int p_md [3] = '{0, 1, 0};
   int p_rl [3] = '{0, 0, 1};

   int            m_r [3];
   int            m_c [3];
   logic [DW-1:0] m_img [3][15][15];
   bit            m_pend [3];
   bit            m_pend_last [3];
   logic [DW-1:0] m_pend_data [3];
   logic [DW-1:0] m_out [3];

   int n_checks = 0;
   int n_errors = 0;
   int n_valid0 = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Pool of the FxF window whose bottom-right corner is (r,c), straight from the frame image
   function automatic logic [DW-1:0] pool(input int d, input int r, input int c);
      logic [DW-1:0] res;
      int f, best, sum, v, q, n;
      res = '0;
      f = p_f[d];
      n = f * f;
      for (int ch = 0; ch < CH; ch++) begin
         best = 1 << 30;
         best = -best;
         sum  = 0;
         for (int i = r - f + 1; i <= r; i++) begin
            for (int j = c - f + 1; j <= c; j++) begin
               v = $signed(m_img[d][i][j][ch*IW +: IW]);
               if (v > best) best = v;
               sum += v;
            end
         end
         if (p_md[d] == 1) begin
            q = sum / n;
            if (sum < 0 && (sum % n) != 0) q = q - 1;
         end else begin
            q = best;
         end
         if (p_rl[d] == 1 && q < 0) q = 0;
         res[ch*IW +: IW] = q[IW-1:0];
      end
      return res;
   endfunction

   task automatic model_accept(input int d, input bit s, input logic [DW-1:0] px);
      int r, c, f, st, n, last;
      n  = p_n[d];
      f  = p_f[d];
      st = p_s[d];
      r  = s ? 0 : m_r[d];
      c  = s ? 0 : m_c[d];
      last = ((n - f) / st) * st + f - 1;
      m_img[d][r][c] = px;
      m_pend[d] = (r >= f - 1) && (c >= f - 1) && ((r - f + 1) % st == 0) && ((c - f + 1) % st == 0);
      m_pend_last[d] = m_pend[d] && (r == last) && (c == last);
      if (m_pend[d]) m_pend_data[d] = pool(d, r, c);
      c = c + 1;
      if (c == n) begin
         c = 0;
         r = (r == n - 1) ? 0 : r + 1;
      end
      m_r[d] = r;
      m_c[d] = c;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_r[d] = 0;
         m_c[d] = 0;
         m_pend[d] = 1'b0;
         m_pend_last[d] = 1'b0;
         m_out[d] = '0;
      end
   endtask

   task automatic step(input bit en, input bit s, input logic [DW-1:0] px);
      @(negedge clk);
      clk_en = en;
      sof = s;
      input_data = px;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         if (m_pend[d]) m_out[d] = m_pend_data[d];
         check($sformatf("valid[%0d]", d), DW'(vd[d]), DW'(m_pend[d]));
         check($sformatf("data[%0d]", d), od[d], m_out[d]);
         check($sformatf("frame_done[%0d]", d), DW'(fd[d]), DW'(m_pend_last[d]));
      end
      if (vd[0]) n_valid0++;
      for (int d = 0; d < 3; d++) begin
         if (en) model_accept(d, s, px);
         else begin
            m_pend[d] = 1'b0;
            m_pend_last[d] = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clk_en = 1'b0;
      sof = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_data[%0d]", d), od[d], '0);
         check($sformatf("rst_valid[%0d]", d), DW'(vd[d]), '0);
         check($sformatf("rst_done[%0d]", d), DW'(fd[d]), '0);
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [DW-1:0] make_px(input int kind, input int k);
      logic [DW-1:0] px;
      int v;
      for (int ch = 0; ch < CH; ch++) begin
         case (kind)
            0:       v = int'($urandom_range(65535)) - 32768;
            1:       v = ($urandom_range(1) == 1) ? 32767 : -32768;
            default: v = (k / 15 * 15 + k % 15) * (ch + 1) - 300;
         endcase
         px[ch*IW +: IW] = v[IW-1:0];
      end
      return px;
   endfunction

   // npix accepted pixels; idle cycles carry random sof/data that must be ignored
   task automatic send_frame(input int kind, input int en_pct, input bit use_sof, input int npix);
      int k;
      bit en;
      k = 0;
      while (k < npix) begin
         en = (int'($urandom_range(99)) < en_pct);
         if (en) begin
            step(1'b1, use_sof && (k == 0), make_px(kind, k));
            k++;
         end else begin
            step(1'b0, 1'($urandom_range(1)), make_px(0, 0));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(1)), make_px(0, 0));
   endtask

   initial begin
      model_reset();
      do_reset();

      send_frame(2, 100, 1'b1, 225);
      idle(3);

      n_valid0 = 0;
      send_frame(0, 70, 1'b1, 225);
      idle(3);
      check("frame_valid_count", DW'(n_valid0), DW'(49));
      send_frame(0, 70, 1'b1, 225);
      send_frame(0, 100, 1'b1, 225);
      idle(3);

      send_frame(1, 100, 1'b1, 225);
      idle(3);

      send_frame(0, 100, 1'b1, 31);
      do_reset();
      n_valid0 = 0;
      send_frame(0, 80, 1'b0, 225);
      idle(3);
      check("post_reset_valid_count", DW'(n_valid0), DW'(49));

      send_frame(0, 100, 1'b1, 17);
      send_frame(0, 90, 1'b1, 225);
      send_frame(0, 90, 1'b0, 225);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stream_pool_layer.md
Name: stream_pool_layer

Overview:
- Parametrised streaming pooling layer; successor to the fixed 2x2 max-pool stage that follows the first convolutional layer in the CNN pipeline.
- Accepts one raster-order pixel per strobe, with all channels packed in one word.
- Generalises window size, stride, channel count and width; adds average mode, fused ReLU, frame resync via sof, a frame_done flag and asynchronous reset.
- Uses line buffers, so windows may overlap (STRIDE < FILTER_SIZE).

Parameters:
I_WIDTH, 16, signed two's-complement width per channel (input and output).
CHANNELS, 5, channels packed per pixel.
IMAGE_SIZE, 15, square input edge length in pixels.
FILTER_SIZE, 2, square window edge; 1..IMAGE_SIZE.
STRIDE, 2, window step in both axes; 1..FILTER_SIZE.
MODE, 0, 0 = max, 1 = average. MODE=1 requires FILTER_SIZE in {1,2,4,8}; any other value is an elaboration error.
RELU, 0, 1 = clamp negative results to 0 before output.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
clk_en  in  1  input strobe; input_data and sof are sampled only when high.
sof  in  1  start of frame; qualifies the current pixel as (row 0, col 0).
input_data  in  CHANNELS*I_WIDTH  pixel; channel k at [k*I_WIDTH +: I_WIDTH].
output_data  out  CHANNELS*I_WIDTH  pooled pixel, same packing as input_data.
valid  out  1  one-cycle pulse; output_data holds a new result.
frame_done  out  1  one-cycle pulse coincident with the last valid of a frame.

Behaviour:
- Reset (rst_n low, async): row/col counters = 0; output_data = 0; valid = 0; frame_done = 0. Line-buffer contents are don't-care and need not be cleared, because no window is evaluated before its rows are refilled. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Accept: a pixel is accepted on a clock edge where clk_en = 1. There is no backpressure and no stall, and the block sustains one pixel per cycle.
- Position: on accept, if sof = 1 the pixel is (0,0) regardless of counters (resync; line buffers are not cleared). Otherwise col increments. At col = IMAGE_SIZE-1, col wraps to 0 and row increments. At row = IMAGE_SIZE-1 and col = IMAGE_SIZE-1, both wrap to 0.
- Storage: FILTER_SIZE-1 line buffers, each IMAGE_SIZE entries of CHANNELS*I_WIDTH, plus a FILTER_SIZE x FILTER_SIZE window register array updated on accept.
- Window fire: a window fires when the accepted pixel (r,c) satisfies all of:
  - r >= F-1 and c >= F-1;
  - (r-(F-1)) mod STRIDE = 0;
  - (c-(F-1)) mod STRIDE = 0.
  Pixels past the last full window are consumed but produce no output.
- Output grid: OUT_SIZE = (IMAGE_SIZE-F)/STRIDE + 1 (floor). Example: 15/2/2 gives 7x7.
- Latency: valid and output_data update on the edge one cycle after the accepting edge. valid is low on every edge with no fire. output_data holds its value between pulses.
- Max mode: per-channel signed maximum over the F*F window.
- Average mode:
  - per-channel signed sum at width I_WIDTH + 2*log2(F);
  - arithmetic right shift by 2*log2(F), i.e. floor toward negative infinity;
  - result always fits I_WIDTH, no saturation.
- RELU = 1: any negative per-channel result becomes 0.
- frame_done: asserted on the same edge as valid for the window whose bottom-right pixel is at row = col = (OUT_SIZE-1)*STRIDE+F-1.
- Overlapping events: sof on the accept edge that would also complete a window means the pixel is treated as (0,0); no fire, no frame_done. clk_en low causes no counter, buffer or window change.

Test Plan:
- CH=1, I=4, F=2, S=2, MODE=0, pixel value = 4r+c, clk_en always high -> 4 valid pulses, outputs 5, 7, 13, 15; frame_done with the 15; each valid 1 cycle after accepting (1,1), (1,3), (3,1), (3,3).
- Same stimulus with MODE=1 -> outputs 2, 4, 10, 12 (floored averages of 2.5, 4.5, 10.5, 12.5).
- Signed: I=4, F=2, S=2, MODE=1, values -1, -2 / -3, -4 in the first window -> output -3 (-10 >>> 2). Same with RELU=1 -> 0. CH=3 with distinct per-channel data -> each lane independent, packing verified.
- Default parameters (15/2/2), random data, random clk_en gaps -> exactly 49 valids matching a reference model; row 14 and col 14 never influence outputs; frame_done on output 49 only; two back-to-back frames correct.
- Overlap: I=5, F=3, S=1, MODE=0 -> 9 outputs, first after pixel (2,2), matching the model.
- Disruptions: rst_n low at pixel (2,1) mid-frame -> outputs immediately 0, then a full clean frame is correct. sof asserted mid-frame at (1,2) -> pixel becomes (0,0), no valid from that pixel, and the following frame is correct.
